sync_fifo_ctrl_64: RTL and testbench
====================================

Name: sync_fifo_ctrl_64

Overview:
Synchronous single-clock FIFO built around a 64-entry, 32-bit two-port storage array. It owns the write and read pointers, the full/empty/almost flags, the occupancy count, flush, and the sticky overflow/underflow errors. It sits between a producer that pushes words and a consumer that pops them. Read data returns one cycle after the pop, matching the registered storage read port.

Parameters:
DATA_W, 32, word width
ADDR_W, 6, address width; depth = 2**ADDR_W = 64
AFULL_TH, 60, almost_full asserted when count >= AFULL_TH
AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of pointers, count and errors
wr_en  in  1  push request
wr_data  in  DATA_W  push data
rd_en  in  1  pop request
rd_data  out  DATA_W  popped word, registered
rd_valid  out  1  rd_data holds a word popped in the previous cycle
full  out  1  count == 64
almost_full  out  1  count >= AFULL_TH
empty  out  1  count == 0
almost_empty  out  1  count <= AEMPTY_TH
count  out  ADDR_W+1  current occupancy, 0..64
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, rd_valid=0, overflow=underflow=0. Storage contents are not reset.
- Pointers are ADDR_W+1 bits. The low ADDR_W bits address storage; the MSB is the wrap bit. Pointers wrap 127->0 naturally.
- Flag derivation:
  - empty: wr_ptr == rd_ptr
  - full: MSBs differ and low bits are equal
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1)
  - All flags and count are registered, or derived purely from registered pointers. They are valid in the same cycle as the pointer update.
- Write accepted: wr_acc = wr_en & ~full. On accept, storage[wr_ptr[5:0]] <= wr_data and wr_ptr increments.
- Read accepted: rd_acc = rd_en & ~empty. On accept, the storage port is read at rd_ptr[5:0] and rd_ptr increments. rd_data is updated at the same edge (latency 1) and rd_valid=1 the following cycle.
  - With no rd_acc, rd_valid=0 and rd_data holds its last value.
- Flags use pre-edge state:
  - Push while full: rejected, no state change, overflow<=1.
  - Pop while empty: rejected, underflow<=1, rd_valid=0.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
- Empty with wr_en & rd_en: write accepted, read rejected, underflow set. The written word is not bypassed to rd_data.
- Full with wr_en & rd_en: read accepted, write rejected, overflow set.
- Storage is read-first. A read and write to the same address in one cycle returns the old contents. The bypass-to-write-data behaviour is forbidden.
- flush=1:
  - Next edge: wr_ptr=rd_ptr=0, rd_valid=0, overflow=underflow=0. rd_data is held.
  - flush overrides wr_en, rd_en and clr_err in that cycle. Nothing is written or popped.
- clr_err=1 clears both sticky bits. A new error in the same cycle wins, and the bit stays set.
- Async reset mid-operation discards all contents. The first cycle after release behaves as empty.

Decomposition:
- Package fifo_pkg holds FIFO_DATA_W=32, FIFO_ADDR_W=6, FIFO_DEPTH=64, default AFULL_TH/AEMPTY_TH, and the count width function (ADDR_W+1).
- One sub-module, sfifo_mem: 2**ADDR_W x DATA_W storage.
  - Write port: synchronous write.
  - Read port: synchronous registered read, read-first.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
  - rdata holds when re=0.
- The controller contains pointers, flags, error logic and rd_valid.

Test Plan:
- Reset, then push 0x00000001..0x00000040 on 64 consecutive cycles -> count=64, full=1, almost_full=1 (count reached 60 after the 60th push), overflow=0.
- From full, push 0xDEADBEEF -> overflow=1, count stays 64. Then pop 64 times -> rd_data sequence 0x1..0x40, each with rd_valid one cycle after rd_en; empty=1 after the last pop.
- Empty, assert wr_en=rd_en=1 with 0xA5A5A5A5 -> count=1, rd_valid=0, underflow=1. Next cycle pop -> rd_data=0xA5A5A5A5.
- Hold count at 10 with wr_en=rd_en=1 for 200 cycles (pointers wrap past 127) -> count stays 10, output order is preserved, and no error is flagged.
- Full with wr_en=rd_en=1 -> the oldest word is returned, count=63, overflow=1. clr_err -> overflow=0 and underflow=0.
- Push 5 words, then assert flush together with wr_en=1 and rd_en=1 -> count=0, empty=1, rd_valid=0. Asserting rst low mid-burst also gives count=0 and every output at its reset value.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing for the synchronous FIFO controller and its storage.
// Default depth/threshold constants plus the occupancy-width helper.
package fifo_pkg;

  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_ADDR_W = 6;
  localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;
  localparam int FIFO_AFULL_TH  = 60;
  localparam int FIFO_AEMPTY_TH = 4;

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Two-port FIFO storage: synchronous write, registered read-first read.
// Contents are deliberately never reset.
module sfifo_mem #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Same-address read sees the pre-write word.
  always_ff @(posedge clk)
    if (re) rdata <= mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl_64.sv
// Single-clock 64x32 FIFO: pointers, flags, count, flush and sticky errors.
// Read data arrives one cycle after an accepted pop.
module sync_fifo_ctrl_64
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AFULL_TH  = FIFO_AFULL_TH,
  parameter int AEMPTY_TH = FIFO_AEMPTY_TH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [cnt_w(ADDR_W)-1:0]   count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int PW = cnt_w(ADDR_W);
  localparam logic [PW-1:0] AF = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE = PW'(AEMPTY_TH);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_q;
  logic              seen;
  logic              wr_acc, rd_acc;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AF);
  assign almost_empty = (count <= AE);

  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Storage read register has no reset; mask it until the first pop.
  assign rd_data = seen ? mem_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      seen      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      if (rd_acc) seen   <= 1'b1;
      rd_valid  <= rd_acc;
      overflow  <= (wr_en & full) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  sfifo_mem #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_q)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl_64.sv
// Directed bench for sync_fifo_ctrl_64: vector table plus
// hand sequences for fill/drain, wrap, full/empty corners and reset.
module tb_sync_fifo_ctrl_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, wr_en, rd_en, clr_err;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid, full, almost_full, empty, almost_empty;
  logic [6:0]  count;
  logic        overflow, underflow;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        fl, we, re, ce;
    logic [31:0] wd;
    logic [6:0]  c;
    logic        e, ae, f, rv;
    logic [31:0] d;
    logic        o, u;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  sync_fifo_ctrl_64 dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .almost_full  (almost_full),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic f, input logic w,
                       input logic [31:0] wd, input logic r,
                       input logic c);
    flush = f; wr_en = w; wr_data = wd; rd_en = r; clr_err = c;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_aempty"}, 32'(almost_empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_rdata"}, rd_data, 0);
    chk({tag, "_rvalid"}, 32'(rd_valid), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
  endtask

  initial begin
    // fl we re ce wd | c e ae f rv d o u
    tbl[0]  = '{1,1,1,0,32'h99, 0,1,1,0,0,32'h1C8,0,0};
    tbl[1]  = '{0,1,0,0,32'h11, 1,0,1,0,0,32'h1C8,0,0};
    tbl[2]  = '{0,1,0,0,32'h22, 2,0,1,0,0,32'h1C8,0,0};
    tbl[3]  = '{0,1,0,0,32'h33, 3,0,1,0,0,32'h1C8,0,0};
    tbl[4]  = '{0,1,0,0,32'h44, 4,0,1,0,0,32'h1C8,0,0};
    tbl[5]  = '{0,1,0,0,32'h55, 5,0,0,0,0,32'h1C8,0,0};
    tbl[6]  = '{1,1,1,1,32'h66, 0,1,1,0,0,32'h1C8,0,0};
    tbl[7]  = '{0,0,1,0,32'h0,  0,1,1,0,0,32'h1C8,0,1};
    tbl[8]  = '{0,0,1,1,32'h0,  0,1,1,0,0,32'h1C8,0,1};
    tbl[9]  = '{0,0,0,1,32'h0,  0,1,1,0,0,32'h1C8,0,0};
    tbl[10] = '{0,1,0,0,32'h77, 1,0,1,0,0,32'h1C8,0,0};
    tbl[11] = '{0,1,1,0,32'h88, 1,0,1,0,1,32'h77,0,0};
    tbl[12] = '{0,0,1,0,32'h0,  0,1,1,0,1,32'h88,0,0};
    tbl[13] = '{0,0,0,0,32'h0,  0,1,1,0,0,32'h88,0,0};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    chk_reset("async_rst");
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk_reset("post_rst");

    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 32'(i), 0, 0);
      cyc();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 60));
      chk("fill_full", 32'(full), 32'(i == 64));
    end
    chk("fill_ovf", 32'(overflow), 0);

    drive(0, 1, 32'hDEADBEEF, 0, 0);
    cyc();
    chk("push_full_ovf", 32'(overflow), 1);
    chk("push_full_count", 32'(count), 64);

    for (int i = 1; i <= 64; i++) begin
      drive(0, 0, 0, 1, 0);
      cyc();
      chk("drain_rvalid", 32'(rd_valid), 1);
      chk("drain_rdata", rd_data, 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    drive(0, 0, 0, 0, 0);
    cyc();
    chk("idle_rvalid", 32'(rd_valid), 0);
    chk("idle_hold", rd_data, 32'h40);

    drive(0, 0, 0, 0, 1);
    cyc();
    chk("clr_ovf", 32'(overflow), 0);

    drive(0, 1, 32'hA5A5A5A5, 1, 0);
    cyc();
    chk("wr_rd_empty_count", 32'(count), 1);
    chk("wr_rd_empty_rvalid", 32'(rd_valid), 0);
    chk("wr_rd_empty_udf", 32'(underflow), 1);
    chk("no_bypass", rd_data, 32'h40);
    drive(0, 0, 0, 1, 0);
    cyc();
    chk("pop_a5", rd_data, 32'hA5A5A5A5);
    chk("pop_a5_rvalid", 32'(rd_valid), 1);

    drive(0, 0, 0, 0, 1);
    cyc();
    chk("clr_udf", 32'(underflow), 0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h100 + 32'(k), 0, 0);
      cyc();
    end
    chk("steady_pre", 32'(count), 10);
    for (int j = 0; j < 200; j++) begin
      drive(0, 1, 32'h10A + 32'(j), 1, 0);
      cyc();
      chk("steady_count", 32'(count), 10);
      chk("steady_rdata", rd_data, 32'h100 + 32'(j));
    end
    chk("steady_ovf", 32'(overflow), 0);
    chk("steady_udf", 32'(underflow), 0);

    for (int k = 0; k < 54; k++) begin
      drive(0, 1, 32'h200 + 32'(k), 0, 0);
      cyc();
    end
    chk("refill_full", 32'(full), 1);
    drive(0, 1, 32'hCAFE0000, 1, 0);
    cyc();
    chk("full_wr_rd_data", rd_data, 32'h1C8);
    chk("full_wr_rd_rvalid", 32'(rd_valid), 1);
    chk("full_wr_rd_count", 32'(count), 63);
    chk("full_wr_rd_ovf", 32'(overflow), 1);
    drive(0, 0, 0, 0, 1);
    cyc();
    chk("clr_both_ovf", 32'(overflow), 0);
    chk("clr_both_udf", 32'(underflow), 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].re, tbl[i].ce);
      cyc();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].c));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e));
      chk($sformatf("v%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].f));
      chk($sformatf("v%0d_rvalid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdata", i), rd_data, tbl[i].d);
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].o));
      chk($sformatf("v%0d_udf", i), 32'(underflow), 32'(tbl[i].u));
    end

    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 32'h300 + 32'(k), 0, 0);
      cyc();
    end
    drive(0, 1, 32'h0, 1, 0);
    cyc();
    chk("burst_rdata", rd_data, 32'h300);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("mid_rst");
    cyc();
    rst = 1'b1;
    drive(0, 0, 0, 1, 0);
    cyc();
    chk("post_rst_rvalid", 32'(rd_valid), 0);
    chk("post_rst_udf", 32'(underflow), 1);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_rdata", rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
